// File: rtl/pebble_pkg.sv
// rtl/pebble_pkg.sv - shared pebble core types and default widths
//
// Purpose: the fetch state encoding, the halt opcode and the address/data
// widths used by fetch, instruction memory and decode.
package pebble_pkg;

  localparam int PEBBLE_ADDR_WIDTH = 10;
  localparam int PEBBLE_DATA_WIDTH = 9;

  // Opcode that ends the program once decode has consumed it.
  localparam logic [PEBBLE_DATA_WIDTH-1:0] PEBBLE_HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction fetch register and decode handshake
//
// Purpose: owns the pc, presents it to instruction memory, captures the returned
// instruction into a fetch register and hands it to decode over valid/ready.
// Handles start, redirects (with flush) from execute, and halt with a sticky done.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start                            one-cycle pulse, begin fetching from RESET_PC
//   imem_addr / imem_instr           instruction memory read address / same-cycle data
//   redirect_valid / redirect_target taken branch or jump, absolute new pc
//   if_valid / if_instr / if_pc      fetch register towards decode
//   id_ready                         decode accepts the fetch register this cycle
//   done                             halt instruction consumed by decode (sticky)
//   fetch_count                      saturating count of instructions handed to decode
module fetch_unit
  import pebble_pkg::*;
#(
  parameter int                    ADDR_WIDTH = PEBBLE_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = PEBBLE_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = PEBBLE_HALT_INSTR,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  id_ready,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic fire;
  logic accept;

  assign fire   = if_valid_q && id_ready;
  assign accept = !if_valid_q || id_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    done_d     = done_q;
    // A fire in the redirect cycle still counts: decode has already sampled it.
    cnt_d      = (fire && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (accept) begin
          if_valid_d = 1'b1;
          if_instr_d = imem_instr;
          if_pc_d    = pc_q;
          // Park the pc on the halt so a frozen unit points at it.
          if (imem_instr == HALT_INSTR) state_d = DRAIN;
          else                          pc_d    = pc_q + PC_ONE;
        end
      end
      DRAIN: begin
        // The fetch register holds the halt; a redirect means it was wrong-path.
        if (redirect_valid) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
          state_d    = RUN;
        end else if (fire) begin
          if_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = HALTED;
        end
      end
      HALTED: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign done        = done_q;
  assign fetch_count = cnt_q;

endmodule
